// File: rtl/ram_dma_copy.sv
// ram_dma_copy
//   Block-copy DMA helper driving the on-chip single-port RAM port. It copies
//   len words from src to dst in ascending order. Each word takes two cycles:
//   RD presents the source address, and WR writes the returned word to the
//   destination. Both addresses wrap modulo 2^AW.
//
//   Optional build macro: RAM_DMA_FILL_EN
//     When defined, a start with fill_i=1 writes the latched pattern_i to len
//     destination words, one word per cycle (FILL state).
//     When undefined, fill_i and pattern_i are ignored.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset; also masks RAM writes at once
//   start_i    start request (sampled only in IDLE)
//   src_i      source word address       (latched on accepted start)
//   dst_i      destination word address  (latched on accepted start)
//   len_i      word count 0..2^LW-1      (latched on accepted start)
//   fill_i     fill mode select          (RAM_DMA_FILL_EN only)
//   pattern_i  fill word                 (RAM_DMA_FILL_EN only)
//   busy_o     transfer in progress
//   done_o     one-cycle completion pulse
//   ram_we_o   RAM write enable
//   ram_adr_o  RAM word address
//   ram_be_o   RAM byte enables
//   ram_dat_o  RAM write data
//   ram_dat_i  RAM read data (valid the cycle after the address)
module ram_dma_copy #(
  parameter int AW = 12,
  parameter int LW = 13
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [LW-1:0] len_i,
  input  logic          fill_i,
  input  logic [31:0]   pattern_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_adr_o,
  output logic [3:0]    ram_be_o,
  output logic [31:0]   ram_dat_o,
  input  logic [31:0]   ram_dat_i
);

`ifdef RAM_DMA_FILL_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_FILL = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3
  } state_t;
`endif

  localparam logic [AW-1:0] ADR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);
  localparam logic [LW-1:0] CNT_ZERO = LW'(0);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          we_s;
  logic [3:0]    be_s;

`ifdef RAM_DMA_FILL_EN
  logic [31:0]   pat_q, pat_d;
`else
  // Fill inputs have no function in this build; the unused_ prefix marks them intentionally sunk.
  logic          unused_fill_s;
  assign unused_fill_s = ^{fill_i, pattern_i};
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
`ifdef RAM_DMA_FILL_EN
      pat_q   <= 32'h0000_0000;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
`ifdef RAM_DMA_FILL_EN
      pat_q   <= pat_d;
`endif
    end
  end

  // Next-state and RAM-port decode. All outputs are decoded from the current state.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
`ifdef RAM_DMA_FILL_EN
    pat_d     = pat_q;
`endif
    busy_o    = 1'b0;
    done_o    = 1'b0;
    we_s      = 1'b0;
    be_s      = 4'h0;
    ram_adr_o = '0;
    ram_dat_o = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            src_d = src_i;
            dst_d = dst_i;
            cnt_d = len_i;
`ifdef RAM_DMA_FILL_EN
            if (fill_i) begin
              pat_d   = pattern_i;
              state_d = S_FILL;
            end else begin
              state_d = S_RD;
            end
`else
            state_d = S_RD;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        busy_o    = 1'b1;
        ram_adr_o = src_q;
        state_d   = S_WR;
      end
      S_WR: begin
        // The word addressed in RD arrives this cycle and is written straight through.
        busy_o    = 1'b1;
        ram_adr_o = dst_q;
        we_s      = 1'b1;
        be_s      = 4'hF;
        ram_dat_o = ram_dat_i;
        src_d     = src_q + ADR_ONE;
        dst_d     = dst_q + ADR_ONE;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
`ifdef RAM_DMA_FILL_EN
      S_FILL: begin
        busy_o    = 1'b1;
        ram_adr_o = dst_q;
        we_s      = 1'b1;
        be_s      = 4'hF;
        ram_dat_o = pat_q;
        dst_d     = dst_q + ADR_ONE;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset asserted during a write cycle must suppress that write, so the
  // strobes are masked combinationally rather than waiting for the edge.
  assign ram_we_o = we_s & ~rst_i;
  assign ram_be_o = be_s & {4{~rst_i}};

endmodule

// File: tb/tb_ram_dma_copy.sv
module tb_ram_dma_copy;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] src;
  logic [11:0] dst;
  logic [12:0] len;
  logic        fill;
  logic [31:0] pattern;
  logic        busy;
  logic        done;
  logic        ram_we;
  logic [11:0] ram_adr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdat;
  logic [31:0] ram_rdat;

  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_adr;
  logic [31:0] pre_dat;

  int checks = 0;
  int errors = 0;
  int busy_cnt, we_cnt, done_cyc;

  ram_dma_copy #(.AW(12), .LW(13)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .src_i    (src),
    .dst_i    (dst),
    .len_i    (len),
    .fill_i   (fill),
    .pattern_i(pattern),
    .busy_o   (busy),
    .done_o   (done),
    .ram_we_o (ram_we),
    .ram_adr_o(ram_adr),
    .ram_be_o (ram_be),
    .ram_dat_o(ram_wdat),
    .ram_dat_i(ram_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle registered read and a bench preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_adr] <= pre_dat;
    end else if (ram_we && ram_be == 4'hF) begin
      mem[ram_adr] <= ram_wdat;
    end
    ram_rdat <= mem[ram_adr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pre_we  = 1'b1;
    pre_adr = a;
    pre_dat = d;
    tick();
    pre_we  = 1'b0;
  endtask

  // Issue one start and observe until done_o (bounded); cycle 1 is the cycle after the start edge.
  task automatic run(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n,
                     input logic f, input logic [31:0] p,
                     output int bc, output int wc, output int dc);
    int cyc;
    src = s; dst = d; len = n; fill = f; pattern = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0; wc = 0; dc = 0; cyc = 1;
    while (cyc <= 200 && dc == 0) begin
      if (busy)   bc++;
      if (ram_we) wc++;
      if (done)   dc = cyc;
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0;
    pattern = 32'h0; pre_we = 1'b0; pre_adr = '0; pre_dat = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we",   {31'd0, ram_we}, 32'd0);
    chk("rst_adr",  {20'd0, ram_adr}, 32'd0);
    chk("rst_be",   {28'd0, ram_be}, 32'd0);
    chk("rst_dat",  ram_wdat, 32'd0);
    rst = 1'b0;
    tick();

    // Basic copy of 4 words
    poke(12'h100, 32'h11111111);
    poke(12'h101, 32'h22222222);
    poke(12'h102, 32'h33333333);
    poke(12'h103, 32'h44444444);
    poke(12'h104, 32'h55555555);
    run(12'h100, 12'h200, 13'd4, 1'b0, 32'h0, busy_cnt, we_cnt, done_cyc);
    chk("copy_busy_cycles", busy_cnt, 32'd8);
    chk("copy_done_cycle",  done_cyc, 32'd9);
    chk("copy_we_cycles",   we_cnt,   32'd4);
    chk("copy_dst0", mem[12'h200], 32'h11111111);
    chk("copy_dst1", mem[12'h201], 32'h22222222);
    chk("copy_dst2", mem[12'h202], 32'h33333333);
    chk("copy_dst3", mem[12'h203], 32'h44444444);
    chk("copy_src0", mem[12'h100], 32'h11111111);
    chk("copy_src3", mem[12'h103], 32'h44444444);
    chk("copy_idle_busy", {31'd0, busy}, 32'd0);
    chk("copy_idle_done", {31'd0, done}, 32'd0);

    // Zero length
    run(12'h100, 12'h200, 13'd0, 1'b0, 32'h0, busy_cnt, we_cnt, done_cyc);
    chk("zero_done_cycle", done_cyc, 32'd1);
    chk("zero_we_cycles",  we_cnt,   32'd0);
    chk("zero_busy_cycles", busy_cnt, 32'd0);

    // Address wrap on the source side
    poke(12'hFFE, 32'hAAAA0FFE);
    poke(12'hFFF, 32'hAAAA0FFF);
    poke(12'h000, 32'hAAAA0000);
    poke(12'h001, 32'hAAAA0001);
    run(12'hFFE, 12'h010, 13'd4, 1'b0, 32'h0, busy_cnt, we_cnt, done_cyc);
    chk("wrap_done_cycle", done_cyc, 32'd9);
    chk("wrap_dst0", mem[12'h010], 32'hAAAA0FFE);
    chk("wrap_dst1", mem[12'h011], 32'hAAAA0FFF);
    chk("wrap_dst2", mem[12'h012], 32'hAAAA0000);
    chk("wrap_dst3", mem[12'h013], 32'hAAAA0001);

    // Overlapping copy replicates the first word
    poke(12'h020, 32'h0000000A);
    poke(12'h021, 32'h0000000B);
    run(12'h020, 12'h021, 13'd3, 1'b0, 32'h0, busy_cnt, we_cnt, done_cyc);
    chk("ovl_src",  mem[12'h020], 32'h0000000A);
    chk("ovl_dst0", mem[12'h021], 32'h0000000A);
    chk("ovl_dst1", mem[12'h022], 32'h0000000A);
    chk("ovl_dst2", mem[12'h023], 32'h0000000A);

    // Fill request (copy when the fill feature is not built)
    run(12'h100, 12'h300, 13'd5, 1'b1, 32'hDEADBEEF, busy_cnt, we_cnt, done_cyc);
    chk("fill_we_cycles", we_cnt, 32'd5);
`ifdef RAM_DMA_FILL_EN
    chk("fill_done_cycle", done_cyc, 32'd6);
    chk("fill_dst0", mem[12'h300], 32'hDEADBEEF);
    chk("fill_dst4", mem[12'h304], 32'hDEADBEEF);
`else
    chk("fill_done_cycle", done_cyc, 32'd11);
    chk("fill_dst0", mem[12'h300], 32'h11111111);
    chk("fill_dst4", mem[12'h304], 32'h55555555);
`endif

    // Reset mid-transfer with a second start while busy
    poke(12'h400, 32'h0);
    poke(12'h401, 32'h0);
    poke(12'h402, 32'h0);
    src = 12'h100; dst = 12'h400; len = 13'd8; fill = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      start = (c == 3);
      rst   = (c == 6);
      #1;
      if (ram_we) we_cnt++;
      if (done)   done_cyc = c;
      tick();
    end
    rst = 1'b0; start = 1'b0;
    #1;
    chk("abort_we_cycles", we_cnt, 32'd2);
    chk("abort_no_done", done_cyc, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we",   {31'd0, ram_we}, 32'd0);
    chk("abort_adr",  {20'd0, ram_adr}, 32'd0);
    chk("abort_be",   {28'd0, ram_be}, 32'd0);
    chk("abort_dat",  ram_wdat, 32'd0);
    chk("abort_dst0", mem[12'h400], 32'h11111111);
    chk("abort_dst1", mem[12'h401], 32'h22222222);
    chk("abort_dst2", mem[12'h402], 32'h00000000);
    done_cyc = 0; busy_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done) done_cyc++;
      if (busy) busy_cnt++;
      tick();
    end
    chk("abort_later_done", done_cyc, 32'd0);
    chk("abort_later_busy", busy_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dma_copy.md
Name: ram_dma_copy

Overview:
- Bus initiator that drives the on-chip single-port RAM port (12-bit word address, 4-bit byte enables, 32-bit write/read data, one-cycle registered read latency).
- Copies a block of words from a source word address to a destination word address in the same RAM, ascending order.
- Sits beside the CPU as a simple DMA helper; the RAM port mux that arbitrates CPU vs. DMA lives outside this block.

Parameters:
- AW, 12, RAM word-address width (4096 words).
- LW, 13, length-counter width (0..4096 words).

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start request; sampled only in IDLE
- src_i  in  AW  source word address, latched on accepted start
- dst_i  in  AW  destination word address, latched on accepted start
- len_i  in  LW  word count, latched on accepted start
- fill_i  in  1  fill mode select (used only with RAM_DMA_FILL_EN)
- pattern_i  in  32  fill word (used only with RAM_DMA_FILL_EN)
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- ram_we_o  out  1  RAM write enable
- ram_adr_o  out  AW  RAM word address
- ram_be_o  out  4  RAM byte enables
- ram_dat_o  out  32  RAM write data
- ram_dat_i  in  32  RAM read data (valid the cycle after the address is presented)

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, ram_we_o=0, ram_adr_o=0, ram_be_o=4'h0, ram_dat_o=0; internal src/dst/count cleared.
- Reset mid-transfer: abort within the same edge. No further RAM writes. No done_o pulse. Words already written stay written.
- States: IDLE, RD, WR, FILL (FILL only with macro), DONE.
- IDLE: ram_we_o=0, ram_be_o=0.
  - start_i=1 and len_i!=0: latch src/dst/len, go to RD (or FILL, see Optional Feature).
  - start_i=1 and len_i==0: go to DONE; no RAM access.
- RD: ram_adr_o=src, ram_we_o=0, ram_be_o=0, busy_o=1. Always go to WR.
- WR: ram_adr_o=dst, ram_we_o=1, ram_be_o=4'hF, ram_dat_o=ram_dat_i (combinational pass of the read word), busy_o=1.
  - On the edge: src+=1, dst+=1, count-=1.
  - If count was 1, go to DONE; else go to RD.
- DONE: done_o=1 for exactly one cycle, busy_o=0, no RAM access. Go to IDLE.
- Throughput: 2 cycles per word. For N>=1, busy_o is high for 2N cycles and done_o pulses on cycle 2N+1 after the start edge. For N=0, done_o pulses on cycle 1.
- Address arithmetic: modulo 2^AW. Words past 4095 wrap to 0 for both src and dst.
- len_i > 4096: transfer continues with wrap. Count is the full LW-bit value; no saturation.
- Overlap: strictly ascending word-by-word. If src < dst <= src+len-1, the already-copied words are re-read, so the pattern replicates. This is defined behaviour, not an error.
- src == dst: rewrites identical data; timing unchanged.
- start_i while busy or in DONE: ignored, not queued.
- Read data is consumed only in WR; ram_dat_i is ignored in all other states.

Optional Feature:
- Macro: RAM_DMA_FILL_EN.
- Defined, start accepted with fill_i=1 and len_i!=0:
  - Latch pattern_i, go to FILL; src is unused.
  - FILL: ram_adr_o=dst, ram_we_o=1, ram_be_o=4'hF, ram_dat_o=latched pattern. dst+=1, count-=1 each cycle.
  - One word per cycle; after the last word go to DONE. For N words, done_o pulses on cycle N+1.
- Not defined:
  - fill_i and pattern_i are ignored; every start performs a copy.
  - FILL state and pattern register are absent.

Test Plan:
- Copy: RAM[0x100..0x103]=0x11111111,0x22222222,0x33333333,0x44444444; start src=0x100 dst=0x200 len=4 -> RAM[0x200..0x203] hold the same values; busy_o high 8 cycles; done_o pulse on cycle 9; src words unchanged.
- Zero length: start len=0 -> done_o pulse on cycle 1; ram_we_o never asserted.
- Wrap: start src=0xFFE dst=0x010 len=4 -> RAM[0x010..0x013] = RAM[0xFFE],RAM[0xFFF],RAM[0x000],RAM[0x001].
- Overlap: RAM[0x20]=0xA, RAM[0x21]=0xB; start src=0x20 dst=0x21 len=3 -> RAM[0x21..0x23]=0xA,0xA,0xA.
- Reset mid-op plus start-while-busy: start len=8; pulse start_i on cycle 3; assert rst_i on cycle 6 -> second start ignored; exactly 2 destination words written (WR on cycles 2 and 4); no done_o pulse; all outputs at reset values on the next cycle.
- Fill (RAM_DMA_FILL_EN): fill_i=1 pattern=0xDEADBEEF dst=0x300 len=5 -> RAM[0x300..0x304]=0xDEADBEEF; ram_we_o high 5 consecutive cycles; done_o on cycle 6. Without the macro, the same stimulus performs a copy.
